// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM states, port ids and lane count.
package mem_arb_pkg;

  localparam int DATA_W_DEFAULT = 32;
  localparam int BE_W = DATA_W_DEFAULT / 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    RESP    = 3'd2,
    RMW_RD  = 3'd3,
    RMW_MRG = 3'd4,
    WR      = 3'd5,
    DONE    = 3'd6
  } state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_t;

endpackage

// File: rtl/mem_byte_merge.sv
// Per-lane merge for partial stores: enabled lanes take the new byte, others keep the old one.
module mem_byte_merge #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   old_word,
  input  logic [DATA_W-1:0]   new_word,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   merged
);

  always_comb begin
    merged = old_word;
    for (int i = 0; i < DATA_W / 8; i++) begin
      if (be[i]) merged[i*8 +: 8] = new_word[i*8 +: 8];
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between an instruction-fetch port and a data port,
// with round-robin arbitration and read-modify-write for byte-enabled stores.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ack,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                ram_wea,
  output logic [ADDR_W-1:0]   ram_addra,
  output logic [DATA_W-1:0]   ram_dina,
  input  logic [DATA_W-1:0]   ram_douta
);

  state_t              state;
  port_t               rr_last;
  port_t               gnt;
  port_t               pick;
  logic [DATA_W/8-1:0] lat_be;
  logic [DATA_W-1:0]   lat_wdata;
  logic [DATA_W-1:0]   merged;

  // Round robin only matters when both ports ask in the same IDLE cycle.
  always_comb begin
    pick = PORT_I;
    if (i_req && d_req) pick = (rr_last == PORT_I) ? PORT_D : PORT_I;
    else if (d_req)     pick = PORT_D;
  end

  mem_byte_merge #(.DATA_W(DATA_W)) u_merge (
    .old_word (ram_douta),
    .new_word (lat_wdata),
    .be       (lat_be),
    .merged   (merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_last   <= PORT_D;
      gnt       <= PORT_I;
      lat_be    <= '0;
      lat_wdata <= '0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      ram_wea   <= 1'b0;
      ram_addra <= '0;
      ram_dina  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            gnt     <= pick;
            rr_last <= pick;
            if (pick == PORT_I) begin
              ram_addra <= i_addr;
              ram_wea   <= 1'b0;
              state     <= RD;
            end else begin
              ram_addra <= d_addr;
              lat_be    <= d_be;
              lat_wdata <= d_wdata;
              if (!d_we) begin
                ram_wea <= 1'b0;
                state   <= RD;
              end else if (&d_be) begin
                ram_dina <= d_wdata;
                ram_wea  <= 1'b1;
                state    <= WR;
              end else if (|d_be) begin
                ram_wea <= 1'b0;
                state   <= RMW_RD;
              end else begin
                d_ack <= 1'b1;
                state <= DONE;
              end
            end
          end
        end
        RD:     state <= RESP;
        RESP: begin
          if (gnt == PORT_I) begin
            i_rdata <= ram_douta;
            i_ack   <= 1'b1;
          end else begin
            d_rdata <= ram_douta;
            d_ack   <= 1'b1;
          end
          state <= DONE;
        end
        RMW_RD: state <= RMW_MRG;
        RMW_MRG: begin
          ram_dina <= merged;
          ram_wea  <= 1'b1;
          state    <= WR;
        end
        WR: begin
          ram_wea <= 1'b0;
          d_ack   <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          i_ack <= 1'b0;
          d_ack <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
